// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
package fetch_pkg;

  localparam int          INST_W           = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } fetchState_t;

  // Instruction addresses must sit on a 4-byte boundary.
  function automatic logic isAligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_timeout.sv
// Counts cycles a fetch request waits for its acknowledge.
// expired pulses on the cycle that completes the ACK_TIMEOUT-th unacknowledged wait.
module fetch_timeout #(
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACK_TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  assign expired = enable && (count == LAST);

  // Wait counter: cleared outside a request, advanced on each unacknowledged cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one memory request per fetch phase, holds the
// returned word for decode, and handles redirects and request faults.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              FeEn,
  input  logic              Advance,
  input  logic              BrTaken,
  input  logic [31:0]       BrTarget,
  output logic              ImReq,
  output logic [31:0]       ImAddr,
  input  logic              ImAck,
  input  logic [INST_W-1:0] ImData,
  output logic              InstValid,
  output logic [INST_W-1:0] Inst,
  output logic [31:0]       Pc,
  output logic              FetchErr
);

  fetchState_t       state;
  logic [31:0]       pcQ;
  logic [INST_W-1:0] instQ;
  logic              waitClear;
  logic              waitEnable;
  logic              waitExpired;

  // The counter only runs while a request is outstanding; a redirect restarts it.
  assign waitClear  = (state != REQ) || BrTaken;
  assign waitEnable = (state == REQ) && !ImAck;

  fetch_timeout #(
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) uTimeout (
    .clk    (clk),
    .rst    (rst),
    .clear  (waitClear),
    .enable (waitEnable),
    .expired(waitExpired)
  );

  // Outputs decode directly from state, so request and valid are mutually exclusive.
  assign ImReq     = (state == REQ);
  assign ImAddr    = pcQ;
  assign InstValid = (state == HOLD);
  assign Inst      = instQ;
  assign Pc        = pcQ;
  assign FetchErr  = (state == ERR);

  // Fetch sequencing; a redirect overrides every other event in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pcQ   <= RESET_PC;
      instQ <= '0;
    end else if (BrTaken) begin
      pcQ   <= BrTarget;
      state <= isAligned(BrTarget) ? IDLE : ERR;
    end else begin
      unique case (state)
        IDLE: begin
          if (FeEn) state <= REQ;
        end
        REQ: begin
          if (ImAck) begin
            instQ <= ImData;
            state <= HOLD;
          end else if (waitExpired) begin
            state <= ERR;
          end
        end
        HOLD: begin
          if (Advance) begin
            pcQ   <= pcQ + 32'd4;
            state <= IDLE;
          end
        end
        ERR: begin
          state <= ERR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written
// multi-cycle sequences, and randomized traffic against a transaction model.
module tb_fetch_unit;

  localparam logic [31:0] RPC2 = 32'hFFFF_FFFC;
  localparam int          TMO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, FeEn, Advance, BrTaken, ImAck;
  logic [31:0] BrTarget, ImData;
  logic        ImReq, InstValid, FetchErr;
  logic [31:0] ImAddr, Inst, Pc;
  logic        ImReq2, InstValid2, FetchErr2;
  logic [31:0] ImAddr2, Inst2, Pc2;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .FeEn(FeEn), .Advance(Advance), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .ImReq(ImReq), .ImAddr(ImAddr), .ImAck(ImAck),
    .ImData(ImData), .InstValid(InstValid), .Inst(Inst), .Pc(Pc), .FetchErr(FetchErr)
  );

  fetch_unit #(.RESET_PC(RPC2), .ACK_TIMEOUT(TMO)) dut2 (
    .clk(clk), .rst(rst), .FeEn(FeEn), .Advance(Advance), .BrTaken(BrTaken),
    .BrTarget(BrTarget), .ImReq(ImReq2), .ImAddr(ImAddr2), .ImAck(ImAck),
    .ImData(ImData), .InstValid(InstValid2), .Inst(Inst2), .Pc(Pc2), .FetchErr(FetchErr2)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chkBit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", name, act, exp);
    end
  endtask

  // Transaction-level reference: where the fetcher is in its life cycle.
  typedef enum {PIdle, PWait, PHold, PFault} phase_t;
  phase_t      mPh   = PIdle;
  logic [31:0] mPc   = 32'h0;
  logic [31:0] mInst = 32'h0;
  int          mWait = 0;

  task automatic modelStep();
    if (rst) begin
      mPh = PIdle; mPc = 32'h0; mInst = 32'h0; mWait = 0;
    end else if (BrTaken) begin
      mPc   = BrTarget;
      mWait = 0;
      mPh   = (BrTarget % 4 != 0) ? PFault : PIdle;
    end else begin
      case (mPh)
        PIdle:  if (FeEn) begin mPh = PWait; mWait = 0; end
        PWait:  if (ImAck) begin
                  mInst = ImData; mPh = PHold;
                end else begin
                  mWait++;
                  if (mWait >= TMO) mPh = PFault;
                end
        PHold:  if (Advance) begin mPc = mPc + 32'd4; mPh = PIdle; end
        default: ;
      endcase
    end
  endtask

  task automatic drive(input logic r, input logic fe, input logic adv, input logic br,
                       input logic [31:0] tgt, input logic ack, input logic [31:0] data);
    rst = r; FeEn = fe; Advance = adv; BrTaken = br; BrTarget = tgt;
    ImAck = ack; ImData = data;
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic checkModel(input string tag);
    chkBit({tag, ".ImReq"},     ImReq,     mPh == PWait);
    chkBit({tag, ".InstValid"}, InstValid, mPh == PHold);
    chkBit({tag, ".FetchErr"},  FetchErr,  mPh == PFault);
    chk({tag, ".Pc"},   Pc,   mPc);
    chk({tag, ".Inst"}, Inst, mInst);
    if (mPh == PWait) chk({tag, ".ImAddr"}, ImAddr, mPc);
    chkBit({tag, ".excl"}, ImReq && InstValid, 1'b0);
  endtask

  typedef struct {
    logic        r, fe, adv, br;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] data;
    logic        eReq, eVal, eErr;
    logic [31:0] ePc, eInst;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic fe, input logic adv, input logic br,
                              input logic [31:0] tgt, input logic ack, input logic [31:0] data,
                              input logic eReq, input logic eVal, input logic eErr,
                              input logic [31:0] ePc, input logic [31:0] eInst);
    vec_t v;
    v.r = r; v.fe = fe; v.adv = adv; v.br = br; v.tgt = tgt; v.ack = ack; v.data = data;
    v.eReq = eReq; v.eVal = eVal; v.eErr = eErr; v.ePc = ePc; v.eInst = eInst;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //                 r  fe adv br tgt          ack data          req val err pc           inst
    tbl.push_back(mk(1, 0, 0, 0, 32'h0,       0, 32'h0,         0, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h0,       32'h0));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h0010_0093, 0, 1, 0, 32'h0,       32'h0010_0093));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       0, 32'h0,         0, 1, 0, 32'h0,       32'h0010_0093));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 32'h0,         0, 0, 0, 32'h4,       32'h0010_0093));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h4,       32'h0010_0093));
    tbl.push_back(mk(0, 0, 0, 1, 32'h200,     1, 32'hDEAD_BEEF, 0, 0, 0, 32'h200,     32'h0010_0093));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h200,     32'h0010_0093));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'h13,        0, 1, 0, 32'h200,     32'h13));
    tbl.push_back(mk(0, 0, 1, 1, 32'h300,     0, 32'h0,         0, 0, 0, 32'h300,     32'h13));
    tbl.push_back(mk(0, 0, 0, 1, 32'h202,     0, 32'h0,         0, 0, 1, 32'h202,     32'h13));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,         0, 0, 1, 32'h202,     32'h13));
    tbl.push_back(mk(0, 1, 1, 0, 32'h0,       1, 32'h77,        0, 0, 1, 32'h202,     32'h13));
    tbl.push_back(mk(0, 0, 0, 1, 32'h104,     0, 32'h0,         0, 0, 0, 32'h104,     32'h13));
    tbl.push_back(mk(0, 1, 0, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h104,     32'h13));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 32'h0,         1, 0, 0, 32'h104,     32'h13));
    tbl.push_back(mk(0, 0, 0, 0, 32'h0,       1, 32'hAAAA_5555, 0, 1, 0, 32'h104,     32'hAAAA_5555));
    tbl.push_back(mk(0, 0, 1, 0, 32'h0,       0, 32'h0,         0, 0, 0, 32'h108,     32'hAAAA_5555));

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t v;
      v = tbl[i];
      drive(v.r, v.fe, v.adv, v.br, v.tgt, v.ack, v.data);
      chkBit($sformatf("row%0d.ImReq", i),     ImReq,     v.eReq);
      chkBit($sformatf("row%0d.InstValid", i), InstValid, v.eVal);
      chkBit($sformatf("row%0d.FetchErr", i),  FetchErr,  v.eErr);
      chk($sformatf("row%0d.Pc", i),   Pc,   v.ePc);
      chk($sformatf("row%0d.Inst", i), Inst, v.eInst);
      if (v.eReq || v.r) chk($sformatf("row%0d.ImAddr", i), ImAddr, v.ePc);
      // Second instance resets to the top word and must wrap on advance.
      if (i == 0) begin
        chk("wrap.resetPc", Pc2, RPC2);
        chk("wrap.resetInst", Inst2, 32'h0);
        chkBit("wrap.resetValid", InstValid2, 1'b0);
        chkBit("wrap.resetErr", FetchErr2, 1'b0);
      end
      if (i == 5) chkBit("wrap.valid", InstValid2, 1'b1);
      if (i == 7) begin
        chk("wrap.pc", Pc2, 32'h0);
        chkBit("wrap.idle", InstValid2, 1'b0);
      end
      if (i == 8) begin
        chkBit("wrap.req", ImReq2, 1'b1);
        chk("wrap.addr", ImAddr2, 32'h0);
      end
    end

    // Timeout: the 16th unacknowledged cycle faults, then a redirect recovers.
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    checkModel("tmo.start");
    for (int k = 0; k < TMO - 1; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      chkBit($sformatf("tmo.wait%0d", k), ImReq, 1'b1);
    end
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    chkBit("tmo.err", FetchErr, 1'b1);
    chkBit("tmo.reqDrop", ImReq, 1'b0);
    drive(0, 0, 0, 1, 32'h100, 0, 32'h0);
    chkBit("tmo.errClr", FetchErr, 1'b0);
    chk("tmo.pc", Pc, 32'h100);
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    chkBit("tmo.refetch", ImReq, 1'b1);
    chk("tmo.addr", ImAddr, 32'h100);

    // Acknowledge arriving on the last allowed cycle still completes the fetch.
    for (int k = 0; k < TMO - 1; k++) begin
      drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
      checkModel($sformatf("edge.wait%0d", k));
    end
    drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0055);
    chkBit("edge.valid", InstValid, 1'b1);
    chkBit("edge.noErr", FetchErr, 1'b0);
    chk("edge.inst", Inst, 32'h55);
    drive(0, 0, 1, 0, 32'h0, 0, 32'h0);
    checkModel("edge.adv");

    // Reset in the middle of a request, then a stale acknowledge.
    drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    chkBit("rstReq.pre", ImReq, 1'b1);
    drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    chkBit("rstReq.ImReq", ImReq, 1'b0);
    chkBit("rstReq.InstValid", InstValid, 1'b0);
    chkBit("rstReq.FetchErr", FetchErr, 1'b0);
    chk("rstReq.Pc", Pc, 32'h0);
    chk("rstReq.ImAddr", ImAddr, 32'h0);
    chk("rstReq.Inst", Inst, 32'h0);
    drive(0, 0, 0, 0, 32'h0, 1, 32'h1234_5678);
    chkBit("lateAck.valid", InstValid, 1'b0);
    chkBit("lateAck.req", ImReq, 1'b0);
    chk("lateAck.inst", Inst, 32'h0);

    // Randomized traffic; acknowledge density varies so timeouts also occur.
    for (int c = 0; c < 3000; c++) begin
      logic        r, fe, adv, br, ack;
      logic [31:0] tgt, data;
      int          ackPct;
      case ((c / 200) % 3)
        0:       ackPct = 35;
        1:       ackPct = 3;
        default: ackPct = 90;
      endcase
      r    = ($urandom_range(0, 199) == 0);
      fe   = ($urandom_range(0, 99) < 70);
      adv  = ($urandom_range(0, 99) < 35);
      br   = ($urandom_range(0, 99) < 5);
      ack  = ($urandom_range(0, 99) < ackPct);
      data = $urandom;
      tgt  = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      drive(r, fe, adv, br, tgt, ack, data);
      checkModel($sformatf("rnd%0d", c));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
